// File: rtl/rs232_pkg.sv
// Shared constants, FSM states and baud divisor helper for the
// buffered RS232 transmitter.
package rs232_pkg;

   localparam int CLK_HZ_DEF = 50_000_000;
   localparam int BAUD_DEF   = 115_200;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Rounded clocks-per-bit
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// Small synchronous byte FIFO; a push is accepted when not full
// or when a pop happens on the same edge.
module rs232_tx_fifo #(
   parameter int AW = 2,
   parameter int W  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count_nxt,
   output logic          empty,
   output logic          accept
);

   localparam int DEPTH = 2 ** AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          do_pop;

   assign empty  = (count == '0);
   assign full   = (count == (AW+1)'(DEPTH));
   assign do_pop = pop && !empty;
   assign accept = push && (!full || do_pop);
   assign dout   = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (accept && !do_pop) begin
         count_nxt = count + (AW+1)'(1);
      end else if (do_pop && !accept) begin
         count_nxt = count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rs232_tx_buffered.sv
// Buffered 8N1 RS232 transmitter with sticky overflow flag.
// Define RS_TX_PARITY_EN to add an even parity bit (8E1 framing).
module rs232_tx_buffered
   import rs232_pkg::*;
#(
   parameter int CLK_HZ  = CLK_HZ_DEF,
   parameter int BAUD    = BAUD_DEF,
   parameter int FIFO_AW = 2
) (
   input  logic       CLK_50MHZ,
   input  logic       RST,
   input  logic [7:0] RS_DATAIN,
   input  logic       RS_TRG_WRITE,
   output logic       TXD,
   output logic       TX_BUSY,
   output logic       FIFO_FULL,
   output logic       OVERFLOW
);

   localparam int DIV   = calc_div(CLK_HZ, BAUD);
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [CW-1:0] TC = CW'(DIV - 1);

   tx_state_t        state, state_nxt;
   logic [CW-1:0]    baud_cnt, baud_cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             txd_nxt;
   logic             pop;
   logic             tc;
   logic [7:0]       head;
   logic [FIFO_AW:0] count_nxt;
   logic             empty;
   logic             accept;
`ifdef RS_TX_PARITY_EN
   logic             par, par_nxt;
`endif

   rs232_tx_fifo #(
      .AW (FIFO_AW),
      .W  (8)
   ) u_fifo (
      .clk       (CLK_50MHZ),
      .rst       (RST),
      .push      (RS_TRG_WRITE),
      .pop       (pop),
      .din       (RS_DATAIN),
      .dout      (head),
      .count_nxt (count_nxt),
      .empty     (empty),
      .accept    (accept)
   );

   assign tc = (baud_cnt == TC);

   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt + CW'(1);
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      txd_nxt      = TXD;
      pop          = 1'b0;
`ifdef RS_TX_PARITY_EN
      par_nxt      = par;
`endif
      unique case (state)
         IDLE: begin
            txd_nxt      = 1'b1;
            baud_cnt_nxt = '0;
            if (!empty) begin
               pop       = 1'b1;
               shift_nxt = head;
               txd_nxt   = 1'b0;
               state_nxt = START;
`ifdef RS_TX_PARITY_EN
               par_nxt   = ^head;
`endif
            end
         end
         START: begin
            if (tc) begin
               baud_cnt_nxt = '0;
               bit_idx_nxt  = '0;
               txd_nxt      = shift[0];
               state_nxt    = DATA;
            end
         end
         DATA: begin
            if (tc) begin
               baud_cnt_nxt = '0;
               shift_nxt    = shift >> 1;
               bit_idx_nxt  = bit_idx + 3'd1;
               txd_nxt      = shift[1];
               if (bit_idx == 3'd7) begin
`ifdef RS_TX_PARITY_EN
                  txd_nxt   = par;
                  state_nxt = PARITY;
`else
                  txd_nxt   = 1'b1;
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef RS_TX_PARITY_EN
         PARITY: begin
            if (tc) begin
               baud_cnt_nxt = '0;
               txd_nxt      = 1'b1;
               state_nxt    = STOP;
            end
         end
`endif
         STOP: begin
            txd_nxt = 1'b1;
            if (tc) begin
               baud_cnt_nxt = '0;
               state_nxt    = IDLE;
            end
         end
         default: begin
            baud_cnt_nxt = '0;
            txd_nxt      = 1'b1;
            state_nxt    = IDLE;
         end
      endcase
   end

   // Status flags are registered from next-state values so they
   // line up with the edge that changes the FIFO or FSM.
   always_ff @(posedge CLK_50MHZ or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         TXD       <= 1'b1;
         TX_BUSY   <= 1'b0;
         FIFO_FULL <= 1'b0;
         OVERFLOW  <= 1'b0;
`ifdef RS_TX_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         baud_cnt  <= baud_cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shift     <= shift_nxt;
         TXD       <= txd_nxt;
         TX_BUSY   <= (state_nxt != IDLE) || (count_nxt != '0);
         FIFO_FULL <= (count_nxt == (FIFO_AW+1)'(DEPTH));
         OVERFLOW  <= OVERFLOW | (RS_TRG_WRITE & ~accept);
`ifdef RS_TX_PARITY_EN
         par       <= par_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rs232_tx_buffered.sv
// Randomised and directed bench for rs232_tx_buffered, checked
// every cycle against a frame-timing model of the serial line.
module tb_rs232_tx_buffered;

   localparam int DIV   = 434;
   localparam int DEPTH = 4;
`ifdef RS_TX_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif

   logic       CLK_50MHZ = 1'b0;
   logic       RST;
   logic [7:0] RS_DATAIN;
   logic       RS_TRG_WRITE;
   logic       TXD;
   logic       TX_BUSY;
   logic       FIFO_FULL;
   logic       OVERFLOW;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   bit         m_act = 0;
   bit         m_ovf = 0;
   int         m_t0  = 0;
   logic [7:0] m_fb  = 8'h00;
   int         cyc   = 0;
   int         k;
   bit         in_pre;
   bit         fr;
   logic [3:0] ex;

   rs232_tx_buffered #(
      .CLK_HZ  (50_000_000),
      .BAUD    (115_200),
      .FIFO_AW (2)
   ) dut (
      .CLK_50MHZ    (CLK_50MHZ),
      .RST          (RST),
      .RS_DATAIN    (RS_DATAIN),
      .RS_TRG_WRITE (RS_TRG_WRITE),
      .TXD          (TXD),
      .TX_BUSY      (TX_BUSY),
      .FIFO_FULL    (FIFO_FULL),
      .OVERFLOW     (OVERFLOW)
   );

   always #10 CLK_50MHZ = ~CLK_50MHZ;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Line level k bit-times into a frame carrying byte b
   function automatic logic line_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef RS_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   function automatic bit in_frame();
      return m_act && ((cyc - m_t0) <= FL * DIV);
   endfunction

   function automatic bit pop_next();
      return !in_frame() && (q.size() > 0);
   endfunction

   function automatic bit m_idle();
      return !in_frame() && (q.size() == 0);
   endfunction

   always @(posedge CLK_50MHZ) begin
      if (RST) begin
         q.delete();
         m_act = 0;
         m_ovf = 0;
         cyc   = 0;
      end else begin
         in_pre = in_frame();
         if (!in_pre && q.size() > 0) begin
            m_fb  = q.pop_front();
            m_t0  = cyc;
            m_act = 1;
         end
         if (RS_TRG_WRITE) begin
            if (q.size() < DEPTH) q.push_back(RS_DATAIN);
            else m_ovf = 1;
         end
         k  = cyc - m_t0;
         fr = m_act && (k < FL * DIV);
         ex = {fr ? line_bit(m_fb, k / DIV) : 1'b1,
               fr || (q.size() > 0),
               q.size() == DEPTH,
               m_ovf};
         cyc++;
         #1 chk("line", {TXD, TX_BUSY, FIFO_FULL, OVERFLOW}, ex);
      end
   end

   task automatic wr(input logic [7:0] b);
      @(negedge CLK_50MHZ);
      RS_DATAIN    = b;
      RS_TRG_WRITE = 1'b1;
   endtask

   task automatic idle_in();
      @(negedge CLK_50MHZ);
      RS_TRG_WRITE = 1'b0;
      RS_DATAIN    = 8'($urandom);
   endtask

   task automatic do_reset();
      @(negedge CLK_50MHZ);
      RS_TRG_WRITE = 1'b0;
      RST = 1'b1;
      repeat (2) @(posedge CLK_50MHZ);
      @(negedge CLK_50MHZ);
      RST = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (!m_idle() && n < 60000) begin
         @(posedge CLK_50MHZ);
         #2 n++;
      end
      chk("drain_bound", n < 60000, 1);
      repeat (3) @(posedge CLK_50MHZ);
   endtask

   initial begin
      int n;
      int lows;
      int busies;
      logic [10:0] pat55;
`ifdef RS_TX_PARITY_EN
      pat55 = 11'b10010101010;
`else
      pat55 = 11'b11010101010;
`endif
      RST          = 1'b1;
      RS_TRG_WRITE = 1'b0;
      RS_DATAIN    = 8'h00;
      repeat (3) @(posedge CLK_50MHZ);
      #1;
      chk("rst_txd", TXD, 1);
      chk("rst_busy", TX_BUSY, 0);
      chk("rst_full", FIFO_FULL, 0);
      chk("rst_ovf", OVERFLOW, 0);
      @(negedge CLK_50MHZ);
      RST = 1'b0;

      // single byte: latency, bit pattern, frame length
      wr(8'h55);
      idle_in();
      @(posedge CLK_50MHZ);
      #1 chk("lat", TXD, 0);
      n = 0;
      while (TX_BUSY && n < 6000) begin
         if ((n % DIV) == DIV / 2 && (n / DIV) < FL)
            chk("b55", TXD, pat55[n/DIV]);
         @(posedge CLK_50MHZ);
         #1 n++;
      end
      chk("busy_len", n, FL * DIV);
      drain();

      // address/data pair two cycles apart
      wr(8'hA5);
      idle_in();
      wr(8'h3C);
      idle_in();
      repeat (FL * DIV - 1) @(posedge CLK_50MHZ);
      #1 chk("gap_hi", TXD, 1);
      @(posedge CLK_50MHZ);
      #1 chk("start2", TXD, 0);
      drain();
      chk("ovf_pair", OVERFLOW, 0);

      // push on the edge that pops a full FIFO
      do_reset();
      for (int i = 1; i <= 5; i++) wr(8'(i));
      idle_in();
      n = 0;
      while (!pop_next() && n < 6000) begin
         @(negedge CLK_50MHZ);
         n++;
      end
      chk("popwait_bound", n < 6000, 1);
      chk("full_pre", FIFO_FULL, 1);
      RS_DATAIN    = 8'h77;
      RS_TRG_WRITE = 1'b1;
      idle_in();
      chk("full_pop", FIFO_FULL, 1);
      chk("ovf_pop", OVERFLOW, 0);

      // six back-to-back strobes into depth 4
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         wr(8'(i));
         if (i == 5) chk("full4", FIFO_FULL, 0);
         if (i == 6) begin
            chk("full5", FIFO_FULL, 1);
            chk("ovf5", OVERFLOW, 0);
         end
      end
      idle_in();
      chk("ovf6", OVERFLOW, 1);
      drain();
      chk("ovf_sticky", OVERFLOW, 1);
      chk("full_end", FIFO_FULL, 0);

      // reset mid data bit 3 with two bytes queued
      do_reset();
      wr(8'h0F);
      wr(8'h11);
      wr(8'h22);
      idle_in();
      repeat (4 * DIV + 100) @(posedge CLK_50MHZ);
      #5 chk("pre_rst_busy", TX_BUSY, 1);
      RST = 1'b1;
      #1;
      chk("arst_txd", TXD, 1);
      chk("arst_busy", TX_BUSY, 0);
      chk("arst_full", FIFO_FULL, 0);
      repeat (2) @(posedge CLK_50MHZ);
      @(negedge CLK_50MHZ);
      RST = 1'b0;
      lows   = 0;
      busies = 0;
      repeat (3000) begin
         @(posedge CLK_50MHZ);
         #1;
         if (!TXD) lows++;
         if (TX_BUSY) busies++;
      end
      chk("quiet_txd", lows, 0);
      chk("quiet_busy", busies, 0);

      // random bytes at random spacing
      for (int i = 0; i < 4; i++) begin
         n = $urandom_range(0, 1200);
         repeat (n) @(negedge CLK_50MHZ);
         wr(8'($urandom));
         idle_in();
      end
      drain();

`ifdef RS_TX_PARITY_EN
      wr(8'h07);
      idle_in();
      repeat (9 * DIV + DIV / 2 + 1) @(posedge CLK_50MHZ);
      #1 chk("par07", TXD, 1);
      drain();
      wr(8'h03);
      idle_in();
      repeat (9 * DIV + DIV / 2 + 1) @(posedge CLK_50MHZ);
      #1 chk("par03", TXD, 0);
      drain();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
